// File: rtl/keypad_pkg.sv
// =============================================================================
// Module      : keypad_pkg
// Description : Shared key codes, FSM state type and (row,col)->key mapping
//               for the 4x3 matrix keypad reader.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_e;

    // Rows 0..2 are the digits 1..9 laid out left to right; the bottom row is *, 0, #.
    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debounce_fsm.sv
// =============================================================================
// Module      : keypad_debounce_fsm
// Description : Scan-rate press/release debouncer producing the key strobe.
//               Auto-repeat is built only when KEYPAD_AUTOREPEAT_EN is defined.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 3
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 20,
    parameter int unsigned REPEAT_RATE    = 5
`endif
) (
    input  logic       clk,
    input  logic       init,
    input  logic       scan_end_i,
    input  logic [3:0] cand_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_SCANS);

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [CW-1:0] w_cnt_inc;
    logic          w_is_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned   RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned   RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] w_rep_inc;
    assign w_rep_inc = rep_q + RW'(1);
`endif

    assign w_cnt_inc = cnt_q + CW'(1);
    assign w_is_key  = (cand_i != KEY_NONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (scan_end_i) begin
            unique case (state_q)
                IDLE: begin
                    if (w_is_key) begin
                        cand_d = cand_i;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = cand_i;
                            key_valid_d = 1'b1;
                            state_d     = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!w_is_key) begin
                        state_d = IDLE;
                    end else if (cand_i == cand_q) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            state_d     = PRESSED;
                        end
                    end else begin
                        cand_d = cand_i;
                        cnt_d  = CW'(1);
                    end
                end
                PRESSED: begin
                    // Any other key while held is ignored until a full release.
                    if (!w_is_key) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_is_key) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        if (scan_end_i) begin
            if (state_q == PRESSED && state_d == PRESSED) begin
                if (cand_i == key_code_q) begin
                    if (w_rep_inc == (rep_first_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                        key_valid_d = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        rep_d = w_rep_inc;
                    end
                end
            end else begin
                rep_d       = '0;
                rep_first_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= KEY_NONE;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

`default_nettype wire

// File: rtl/keypad_scan_decoder.sv
// =============================================================================
// Module      : keypad_scan_decoder
// Description : 4x3 keypad row scanner with snapshot ghost check and debounce.
//               Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000000,
    parameter int unsigned DEBOUNCE_SCANS = 3
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 20,
    parameter int unsigned REPEAT_RATE    = 5
`endif
) (
    input  logic       clk,
    input  logic       init,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned   DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [11:0]   snap_q, snap_d;
    logic          w_last;
    logic          w_scan_end;
    logic [3:0]    w_nbits;
    logic [3:0]    w_code;
    logic [3:0]    w_cand;

    assign w_last     = (dwell_q == DWELL_LAST);
    assign w_scan_end = w_last && (ridx_q == 2'd3);
    assign row        = 4'b0001 << ridx_q;

    // The snapshot register is the only flop on the column path; sampling on the
    // last dwell cycle gives the row drive the whole dwell to settle.
    always_comb begin
        dwell_d = w_last ? '0 : dwell_q + DW'(1);
        ridx_d  = w_last ? ridx_q + 2'd1 : ridx_q;
        snap_d  = snap_q;
        if (w_last) begin
            snap_d[3*ridx_q +: 3] = col;
        end
    end

    // Evaluated on the next-snapshot so the bottom row sampled this cycle counts.
    always_comb begin
        w_nbits = '0;
        w_code  = KEY_NONE;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (snap_d[r*3 + c]) begin
                    w_nbits = w_nbits + 4'd1;
                    w_code  = key_of(2'(r), 2'(c));
                end
            end
        end
        w_cand = (w_nbits == 4'd1) ? w_code : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            dwell_q <= '0;
            ridx_q  <= 2'd0;
            snap_q  <= '0;
        end else begin
            dwell_q <= dwell_d;
            ridx_q  <= ridx_d;
            snap_q  <= snap_d;
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_fsm (
        .clk         (clk),
        .init        (init),
        .scan_end_i  (w_scan_end),
        .cand_i      (w_cand),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_held_o  (key_held)
    );

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_decoder.sv
// =============================================================================
// Module      : tb_keypad_scan_decoder
// Description : Scoreboard bench for keypad_scan_decoder (SCAN_DIV=4, 3 scans).
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_keypad_scan_decoder;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic [2:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] held = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          q_exp[$];

    int kmap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    // Reference state: a press is reported after D identical single-key scans
    // while armed; re-arming needs D consecutive empty scans.
    bit m_armed;
    int m_run_key, m_run_len, m_none_run, m_last_code;

    keypad_scan_decoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (D)
    ) dut (
        .clk       (clk),
        .init      (init),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | held[3*r +: 3];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_cand(input logic [11:0] s);
        if ($countones(s) != 1) return 15;
        for (int i = 0; i < 12; i++) begin
            if (s[i]) return kmap[i];
        end
        return 15;
    endfunction

    task automatic model_reset();
        m_armed     = 1'b1;
        m_run_key   = 15;
        m_run_len   = 0;
        m_none_run  = 0;
        m_last_code = 15;
    endtask

    task automatic model_eval(input logic [11:0] s);
        int c;
        c = m_cand(s);
        if (m_armed) begin
            if (c == 15) begin
                m_run_len = 0;
            end else if (c == m_run_key && m_run_len > 0) begin
                m_run_len++;
            end else begin
                m_run_key = c;
                m_run_len = 1;
            end
            if (m_run_len == D) begin
                q_exp.push_back(c);
                m_last_code = c;
                m_armed     = 1'b0;
                m_none_run  = 0;
            end
        end else begin
            if (c == 15) begin
                m_none_run++;
                if (m_none_run == D) begin
                    m_armed   = 1'b1;
                    m_run_len = 0;
                end
            end else begin
                m_none_run = 0;
            end
        end
    endtask

    // Must be called on a negedge; leaves the bench aligned to a fresh scan.
    task automatic do_reset();
        init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init = 1'b0;
        model_reset();
        chk("reset_row", row, 1);
        chk("reset_key_code", key_code, 15);
        chk("reset_key_held", key_held, 0);
        chk("reset_key_valid", key_valid, 0);
    endtask

    task automatic scans(input logic [11:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            chk("key_held", key_held, m_armed ? 0 : 1);
            chk("key_code_hold", key_code, m_last_code);
            held = s;
            model_eval(s);
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                chk("row", row, 1 << ((k / 4) % 4));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!init && key_valid) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got key_valid with code %0d, expected no strobe at %0t",
                         key_code, $time);
            end else begin
                chk("strobe_code", key_code, q_exp.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cur;
        int          r;
        model_reset();
        @(negedge clk);
        do_reset();

        scans(12'h000, 13);                          // idle scanning
        scans(12'h010, 5);  scans(12'h000, 4);       // key 5
        scans(12'h010, 2);  scans(12'h000, 1);       // key 5 interrupted
        scans(12'h010, 4);  scans(12'h000, 4);
        scans(12'hA00, 10);                          // * and # together: ghost
        scans(12'h200, 4);  scans(12'h000, 4);       // * alone
        scans(12'h100, 4);  scans(12'h000, 1);       // 9 with short bounce
        scans(12'h100, 3);  scans(12'h000, 3);
        scans(12'h400, 4);  scans(12'h000, 4);       // 0
        scans(12'h001, 5);                           // 1, then init mid-scan
        held = 12'h001;
        repeat (7) @(negedge clk);
        do_reset();
        scans(12'h001, 4);  scans(12'h000, 4);

        cur = '0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cur = cur;
            end else if (r < 6) begin
                cur = '0;
            end else if (r < 9) begin
                cur = 12'b1 << $urandom_range(0, 11);
            end else begin
                cur = (12'b1 << $urandom_range(0, 11)) | (12'b1 << $urandom_range(0, 11));
            end
            scans(cur, $urandom_range(1, 4));
        end
        scans(12'h000, 4);

        repeat (3) @(negedge clk);
        chk("pending_strobes", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
